// File: rtl/rcl_arbiter.sv
// rcl_arbiter: round-robin sharing of one line/circle relation engine between N_REQ requesters.
// Optional WAIT watchdog enabled by defining RCL_ARB_TIMEOUT_EN.
module rcl_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [15*N_REQ-1:0]  req_coef_L,
    input  logic [15*N_REQ-1:0]  req_coef_Q,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [1:0]           rsp_out,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_in_valid,
    output logic [4:0]           eng_coef_L,
    output logic [4:0]           eng_coef_Q,
    input  logic                 eng_out_valid,
    input  logic [1:0]           eng_out
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = TIMEOUT_CYC > 3 ? $clog2(TIMEOUT_CYC + 1) : 2;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;
    state_t state_q;
    logic [IW-1:0] rr_q, id_q, off, sel, sel_nxt;
    logic [IW:0] sum;
    logic [N_REQ-1:0] rot, gnt_q, rsp_valid_q;
    logic [14:0] cl [N_REQ];
    logic [14:0] cq [N_REQ];
    logic [14:0] cl_q, cq_q;
    logic [CW-1:0] cnt_q;
    logic [1:0] rsp_out_q;
    logic eng_v_q;
    logic [4:0] eng_l_q, eng_q_q, bl, bq;
    // Rotate requests so the scan starts at rr_ptr; the lowest set bit of rot is the winner offset.
    always_comb begin
        rot = N_REQ'({req, req} >> rr_q);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) off = IW'(k);
        sum = {1'b0, rr_q} + {1'b0, off};
        sel = sum >= (IW+1)'(N_REQ) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
        sel_nxt = sel == IW'(N_REQ - 1) ? '0 : sel + IW'(1);
        for (int i = 0; i < N_REQ; i++) begin
            cl[i] = req_coef_L[15*i +: 15];
            cq[i] = req_coef_Q[15*i +: 15];
        end
        bl = cnt_q == CW'(0) ? cl_q[4:0] : cnt_q == CW'(1) ? cl_q[9:5] : cl_q[14:10];
        bq = cnt_q == CW'(0) ? cq_q[4:0] : cnt_q == CW'(1) ? cq_q[9:5] : cq_q[14:10];
    end
`ifdef RCL_ARB_TIMEOUT_EN
    logic rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            cl_q        <= '0;
            cq_q        <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_out_q   <= '0;
            eng_v_q     <= 1'b0;
            eng_l_q     <= '0;
            eng_q_q     <= '0;
`ifdef RCL_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            eng_v_q     <= 1'b0;
            eng_l_q     <= '0;
            eng_q_q     <= '0;
            case (state_q)
                IDLE: if (|req) begin
                    gnt_q   <= N_REQ'(1) << sel;
                    id_q    <= sel;
                    cl_q    <= cl[sel];
                    cq_q    <= cq[sel];
                    rr_q    <= sel_nxt;
                    cnt_q   <= '0;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    eng_v_q <= 1'b1;
                    eng_l_q <= bl;
                    eng_q_q <= bq;
                    cnt_q   <= cnt_q == CW'(2) ? '0 : cnt_q + CW'(1);
                    if (cnt_q == CW'(2)) state_q <= WAIT;
                end
                WAIT: begin
                    if (eng_out_valid) begin
                        rsp_valid_q <= N_REQ'(1) << id_q;
                        rsp_out_q   <= eng_out;
                        state_q     <= RESP;
                    end
`ifdef RCL_ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_valid_q <= N_REQ'(1) << id_q;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else cnt_q <= cnt_q + CW'(1);
`endif
                end
                RESP: begin
                    rsp_out_q <= '0;
`ifdef RCL_ARB_TIMEOUT_EN
                    rsp_err_q <= 1'b0;
`endif
                    state_q   <= GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_out      = rsp_out_q;
    assign busy         = state_q != IDLE;
    assign eng_in_valid = eng_v_q;
    assign eng_coef_L   = eng_l_q;
    assign eng_coef_Q   = eng_q_q;
endmodule

// File: tb/tb_rcl_arbiter.sv
// tb_rcl_arbiter: vector table, directed corner sequences and random jobs against a round-robin reference model.
module tb_rcl_arbiter;
    localparam int N = 4;
    localparam int TO = 31;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [59:0] cL = '0, cQ = '0;
    logic [3:0] gnt, rsp_valid;
    logic [1:0] rsp_out, eng_out = '0;
    logic rsp_err, busy, eng_in_valid, eng_out_valid = 1'b0;
    logic [4:0] eng_coef_L, eng_coef_Q;
    int checks = 0, failures = 0, m_rr = 0, wt, n;
    typedef struct {logic [3:0] r; logic [3:0] g; logic [1:0] res; int lat;} vec_t;
    vec_t tbl[8];
    logic [3:0] rr_seq[5];

    rcl_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_coef_L(cL), .req_coef_Q(cQ),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_err(rsp_err), .busy(busy),
        .eng_in_valid(eng_in_valid), .eng_coef_L(eng_coef_L), .eng_coef_Q(eng_coef_Q),
        .eng_out_valid(eng_out_valid), .eng_out(eng_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, want);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int rr);
        logic [1:0] ix;
        for (int k = 0; k < N; k++) begin
            ix = 2'(rr + k);
            if (r[ix]) return int'(ix);
        end
        return -1;
    endfunction

    function automatic logic [4:0] slice5(input logic [59:0] v, input int w, input int b);
        return 5'(v >> (15 * w + 5 * b));
    endfunction

    always @(negedge clk) begin
        checks++;
        if (int'(gnt != 0) + int'(rsp_valid != 0) + int'(eng_in_valid) > 1 ||
            $countones(gnt) > 1 || $countones(rsp_valid) > 1) begin
            failures++;
            $display("FAIL exclusive gnt=%b rsp_valid=%b eng_in_valid=%b", gnt, rsp_valid, eng_in_valid);
        end
    end

    task automatic do_job(input logic [3:0] eg, input logic [1:0] res, input int lat,
                          input logic [3:0] nreq, input logic [3:0] late, output int wtd);
        int w = 0, cnt, to_path = 0;
        logic [59:0] L, Q;
        logic [1:0] e_out = res;
        logic e_err = 1'b0;
        for (int i = 0; i < N; i++) if (eg == 4'(1 << i)) w = i;
        wtd = 0;
        do begin @(negedge clk); wtd++; end while (gnt == 0 && wtd < 20);
        chk("gnt", 32'(gnt), 32'(eg));
        L = cL; Q = cQ; req = nreq;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            chk("beat_valid", 32'(eng_in_valid), 1);
            chk("beat_L", 32'(eng_coef_L), 32'(slice5(L, w, b)));
            chk("beat_Q", 32'(eng_coef_Q), 32'(slice5(Q, w, b)));
        end
        if (late != 0) req = late;
        cnt = 0;
        if (lat < 0) begin
`ifdef RCL_ARB_TIMEOUT_EN
            to_path = 1;
            do begin @(negedge clk); cnt++; end while (rsp_valid == 0 && cnt < 60);
            chk("timeout_cycles", cnt, TO);
            e_err = 1'b1; e_out = 2'd0;
`else
            repeat (40) begin @(negedge clk); if (busy && rsp_valid == 0 && !eng_in_valid) cnt++; end
            chk("wait_hold", cnt, 40);
`endif
        end else begin
            repeat (lat) begin
                @(negedge clk);
                if (!busy || eng_in_valid || rsp_valid != 0 || gnt != 0) cnt++;
            end
            chk("wait_quiet", cnt, 0);
        end
        if (to_path == 0) begin
            eng_out_valid = 1'b1; eng_out = res;
            @(negedge clk);
            eng_out_valid = 1'b0; eng_out = ~res;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(eg));
        chk("rsp_out", 32'(rsp_out), 32'(e_out));
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("eng_idle", 32'({eng_in_valid, eng_coef_L, eng_coef_Q}), 0);
        @(negedge clk);
        eng_out_valid = 1'b1; eng_out = 2'd2;
        chk("gap", 32'({busy, gnt, rsp_valid}), 32'h100);
        @(negedge clk);
        eng_out_valid = 1'b0;
        chk("idle", 32'({busy, gnt, rsp_valid}), 0);
        m_rr = (w + 1) % N;
    endtask

    initial begin
        tbl = '{'{4'hF, 4'b1000, 2'd2, 1}, '{4'hF, 4'b0001, 2'd0, 2}, '{4'hF, 4'b0010, 2'd1, 1},
                '{4'hF, 4'b0100, 2'd2, 3}, '{4'b0011, 4'b0001, 2'd1, 1}, '{4'b0001, 4'b0001, 2'd0, 1},
                '{4'b1001, 4'b1000, 2'd2, 2}, '{4'b0110, 4'b0010, 2'd1, 1}};
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // reset state, then first grant one cycle after release
        req = 4'hF;
        cL = 60'({$urandom(), $urandom()}); cQ = 60'({$urandom(), $urandom()});
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({gnt, rsp_valid, rsp_out, rsp_err, busy, eng_in_valid, eng_coef_L, eng_coef_Q}), 0);
        rst_n = 1'b1;
        do_job(4'b0001, 2'd2, 1, 4'b0, 4'b0, wt);
        chk("t1_latency", wt, 1);
        // single job with known coefficients on requester 2
        req = 4'b0100;
        cL = 60'({5'd3, 5'd1, 5'd0}) << 30; cQ = 60'({5'd9, 5'd3, 5'd0}) << 30;
        do_job(4'b0100, 2'd1, 1, 4'b0, 4'b0, wt);
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].r;
            cL = 60'({$urandom(), $urandom()}); cQ = 60'({$urandom(), $urandom()});
            do_job(tbl[i].g, tbl[i].res, tbl[i].lat, 4'b0, 4'b0, wt);
        end
        // late request during WAIT is held off until after GAP
        req = 4'b0001;
        do_job(4'b0001, 2'd1, 2, 4'b0, 4'b0010, wt);
        do_job(4'b0010, 2'd2, 1, 4'b0, 4'b0, wt);
        chk("t4_latency", wt, 1);
        // reset in the middle of ISSUE
        req = 4'b0100;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 0 && n < 20);
        chk("t5_gnt", 32'(gnt), 32'h4);
        req = 4'b0;
        repeat (2) @(negedge clk);
        chk("t5_beat1", 32'(eng_in_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outs", 32'({gnt, rsp_valid, rsp_out, rsp_err, busy, eng_in_valid, eng_coef_L, eng_coef_Q}), 0);
        req = 4'hF;
        repeat (2) @(negedge clk);
        chk("t5_held", 32'({gnt, rsp_valid, busy}), 0);
        rst_n = 1'b1;
        m_rr = 0;
        // round robin with all requests held
        for (int i = 0; i < 5; i++) begin
            do_job(rr_seq[i], 2'(i % 3), 1, i < 4 ? 4'hF : 4'h0, 4'b0, wt);
            chk("t3_spacing", wt, 1);
        end
        // engine never replies
        req = 4'b0010;
        cL = 60'({$urandom(), $urandom()}); cQ = 60'({$urandom(), $urandom()});
        do_job(4'b0010, 2'd1, -1, 4'b0, 4'b0, wt);
        for (int it = 0; it < 40; it++) begin
            logic [3:0] r;
            int w;
            r = 4'($urandom_range(0, 15));
            cL = 60'({$urandom(), $urandom()}); cQ = 60'({$urandom(), $urandom()});
            req = r;
            if (r == 0) begin
                n = 0;
                repeat (3) begin @(negedge clk); if (gnt != 0 || busy) n++; end
                chk("no_req_idle", n, 0);
            end else begin
                w = pick(r, m_rr);
                do_job(4'(1 << w), 2'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 4'b0, 4'b0, wt);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
